// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller for the five-stage RV64 core.
//
// Turns hazard reports into per-stage stall/flush vectors and a PC redirect.
// Bit order of stall_o/flush_o: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem,
// [4] mem_wb. Outputs are combinational from the current state and inputs;
// state, saved return state, pending redirect PC and counters are registered.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs_id_ex_hit_i           ID source matches EX destination
//   ex_is_load_i             EX holds a load
//   jump_i, jump_addr_i      EX resolved taken jump/branch and its target
//   trap_i, trap_addr_i      trap request and trap vector
//   ifetch_busy_i            instruction fetch not ready
//   dmem_busy_i              MEM-stage data access not complete
//   muldiv_start_i/done_i    mul/div entered EX / result valid
//   stall_o, flush_o         per-register hold / bubble vectors
//   redirect_o, redirect_pc_o  load PC with redirect_pc_o
//   muldiv_kill_o            abort in-flight mul/div
//   state_o                  0 RUN, 1 MEM_WAIT, 2 MULDIV, 3 REDIR_PEND
//   stall_cnt_o, redir_cnt_o saturating counters of PC-stall / redirect cycles
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rs_id_ex_hit_i,
  input  logic             ex_is_load_i,
  input  logic             jump_i,
  input  logic [63:0]      jump_addr_i,
  input  logic             trap_i,
  input  logic [63:0]      trap_addr_i,
  input  logic             ifetch_busy_i,
  input  logic             dmem_busy_i,
  input  logic             muldiv_start_i,
  input  logic             muldiv_done_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             redirect_o,
  output logic [63:0]      redirect_pc_o,
  output logic             muldiv_kill_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_MULDIV     = 2'd2,
    ST_REDIR_PEND = 2'd3
  } state_t;

  state_t      state, state_nxt;
  state_t      ret_state, ret_nxt;
  state_t      eff_state, base_state;
  logic [63:0] pend_pc, pend_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_comb begin
    stall_o       = 5'b00000;
    flush_o       = 5'b00000;
    redirect_o    = 1'b0;
    redirect_pc_o = 64'd0;
    muldiv_kill_o = 1'b0;
    state_nxt     = state;
    ret_nxt       = ret_state;
    pend_nxt      = pend_pc;

    // While waiting on memory the pipeline is logically still in the state it
    // came from; once busy drops that state resumes in the same cycle.
    eff_state = (state == ST_MEM_WAIT) ? ret_state : state;
    // The mul/div done cycle behaves as RUN for everything below it.
    base_state = (eff_state == ST_MULDIV && muldiv_done_i) ? ST_RUN : eff_state;

    if (trap_i) begin
      redirect_o    = 1'b1;
      redirect_pc_o = trap_addr_i;
      flush_o       = 5'b01110;
      muldiv_kill_o = (state == ST_MULDIV);
      state_nxt     = ST_RUN;
      ret_nxt       = ST_RUN;
      pend_nxt      = 64'd0;
    end else if (dmem_busy_i) begin
      stall_o   = 5'b01111;
      flush_o   = 5'b10000;
      state_nxt = ST_MEM_WAIT;
      // A mul/div that completes under the memory stall must not be resumed.
      ret_nxt   = base_state;
    end else begin
      state_nxt = base_state;
      if (base_state == ST_MULDIV || (base_state == ST_RUN && muldiv_start_i)) begin
        stall_o   = 5'b00111;
        flush_o   = 5'b01000;
        state_nxt = ST_MULDIV;
      end else if (base_state == ST_RUN && jump_i) begin
        flush_o = 5'b00110;
        if (!ifetch_busy_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = jump_addr_i;
        end else begin
          pend_nxt  = jump_addr_i;
          state_nxt = ST_REDIR_PEND;
        end
      end else if (base_state == ST_REDIR_PEND) begin
        stall_o = 5'b00001;
        flush_o = 5'b00010;
        if (!ifetch_busy_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = pend_pc;
          state_nxt     = ST_RUN;
        end
      end else if (rs_id_ex_hit_i && ex_is_load_i) begin
        stall_o = 5'b00011;
        flush_o = 5'b00100;
      end else if (ifetch_busy_i) begin
        stall_o = 5'b00001;
        flush_o = 5'b00010;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      pend_pc     <= 64'd0;
      stall_cnt_o <= '0;
      redir_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      ret_state   <= ret_nxt;
      pend_pc     <= pend_nxt;
      stall_cnt_o <= sat_inc(stall_cnt_o, stall_o[0]);
      redir_cnt_o <= sat_inc(redir_cnt_o, redirect_o);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic hit, ld, jmp, trp, ifb, dmb, mst, mdn;
  logic [63:0] jaddr, taddr;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_o, muldiv_kill_o;
  logic [63:0] redirect_pc_o;
  logic [1:0]  state_o;
  logic [CW-1:0] stall_cnt_o, redir_cnt_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic          redir;
    logic [63:0]   pc;
    logic          kill;
    logic [1:0]    st;
    logic [CW-1:0] scnt;
    logic [CW-1:0] rcnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] m_scnt, m_rcnt;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs_id_ex_hit_i(hit), .ex_is_load_i(ld),
    .jump_i(jmp), .jump_addr_i(jaddr),
    .trap_i(trp), .trap_addr_i(taddr),
    .ifetch_busy_i(ifb), .dmem_busy_i(dmb),
    .muldiv_start_i(mst), .muldiv_done_i(mdn),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .muldiv_kill_o(muldiv_kill_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .redir_cnt_o(redir_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".stall"}, 64'(stall_o), 64'(e.stall));
      check({e.name, ".flush"}, 64'(flush_o), 64'(e.flush));
      check({e.name, ".redir"}, 64'(redirect_o), 64'(e.redir));
      check({e.name, ".pc"}, redirect_pc_o, e.pc);
      check({e.name, ".kill"}, 64'(muldiv_kill_o), 64'(e.kill));
      check({e.name, ".state"}, 64'(state_o), 64'(e.st));
      check({e.name, ".stall_cnt"}, 64'(stall_cnt_o), 64'(e.scnt));
      check({e.name, ".redir_cnt"}, 64'(redir_cnt_o), 64'(e.rcnt));
    end
  end

  task automatic idle();
    hit = 0; ld = 0; jmp = 0; trp = 0; ifb = 0; dmb = 0; mst = 0; mdn = 0;
    jaddr = 64'd0; taddr = 64'd0;
  endtask

  // Push this cycle's expectation, then advance one clock.
  task automatic cyc(input string name, input logic [4:0] s, input logic [4:0] f,
                     input logic r, input logic [63:0] pc, input logic k,
                     input logic [1:0] st);
    exp_t e;
    e.stall = s; e.flush = f; e.redir = r; e.pc = pc; e.kill = k; e.st = st;
    e.scnt = m_scnt; e.rcnt = m_rcnt; e.name = name;
    exp_q.push_back(e);
    if (!rst) begin
      if (s[0] && m_scnt != 4'hF) m_scnt++;
      if (r && m_rcnt != 4'hF) m_rcnt++;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1; idle();
    m_scnt = 0; m_rcnt = 0;
    cyc("reset", 5'b0, 5'b0, 0, 0, 0, 0);
    rst = 0;
  endtask

  initial begin
    rst = 1; idle(); m_scnt = 0; m_rcnt = 0;
    @(posedge clk); #1;
    do_reset();

    // load-use bubble, then plain forwarding hit
    hit = 1; ld = 1; cyc("lu", 5'b00011, 5'b00100, 0, 0, 0, 0);
    cyc("lu_after", 5'b0, 5'b0, 0, 0, 0, 0);
    hit = 1; cyc("fwd_only", 5'b0, 5'b0, 0, 0, 0, 0);

    // jump while fetch busy for 3 cycles
    do_reset();
    jmp = 1; jaddr = 64'h8000_0040; ifb = 1;
    cyc("jmp", 5'b0, 5'b00110, 0, 0, 0, 0);
    ifb = 1; cyc("pend1", 5'b00001, 5'b00010, 0, 0, 0, 3);
    ifb = 1; cyc("pend2", 5'b00001, 5'b00010, 0, 0, 0, 3);
    cyc("pend_rd", 5'b00001, 5'b00010, 1, 64'h8000_0040, 0, 3);
    cyc("pend_done", 5'b0, 5'b0, 0, 0, 0, 0);

    // jump with fetch ready: zero-latency redirect
    jmp = 1; jaddr = 64'h1234; cyc("jmp_now", 5'b0, 5'b00110, 1, 64'h1234, 0, 0);

    // mul/div, done 4 cycles after start
    do_reset();
    mst = 1; cyc("md0", 5'b00111, 5'b01000, 0, 0, 0, 0);
    cyc("md1", 5'b00111, 5'b01000, 0, 0, 0, 2);
    cyc("md2", 5'b00111, 5'b01000, 0, 0, 0, 2);
    cyc("md3", 5'b00111, 5'b01000, 0, 0, 0, 2);
    mdn = 1; cyc("md_done", 5'b0, 5'b0, 0, 0, 0, 2);
    cyc("md_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // trap during mul/div wait
    mst = 1; cyc("mdt0", 5'b00111, 5'b01000, 0, 0, 0, 0);
    cyc("mdt1", 5'b00111, 5'b01000, 0, 0, 0, 2);
    trp = 1; taddr = 64'h100; cyc("mdt_trap", 5'b0, 5'b01110, 1, 64'h100, 1, 2);
    cyc("mdt_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // dmem busy during pending redirect
    do_reset();
    jmp = 1; jaddr = 64'h8000_1000; ifb = 1; cyc("rm_jmp", 5'b0, 5'b00110, 0, 0, 0, 0);
    ifb = 1; dmb = 1; cyc("rm_mem1", 5'b01111, 5'b10000, 0, 0, 0, 3);
    ifb = 1; dmb = 1; cyc("rm_mem2", 5'b01111, 5'b10000, 0, 0, 0, 1);
    ifb = 1; cyc("rm_back", 5'b00001, 5'b00010, 0, 0, 0, 1);
    cyc("rm_rd", 5'b00001, 5'b00010, 1, 64'h8000_1000, 0, 3);
    cyc("rm_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // trap in REDIR_PEND discards the pending target
    jmp = 1; jaddr = 64'h8000_2000; ifb = 1; cyc("tp_jmp", 5'b0, 5'b00110, 0, 0, 0, 0);
    trp = 1; taddr = 64'h200; ifb = 1; cyc("tp_trap", 5'b0, 5'b01110, 1, 64'h200, 0, 3);
    cyc("tp_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // trap beats dmem busy
    trp = 1; taddr = 64'h300; dmb = 1; cyc("td", 5'b0, 5'b01110, 1, 64'h300, 0, 0);
    cyc("td_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // mul/div done under dmem busy returns to RUN
    do_reset();
    mst = 1; cyc("mm0", 5'b00111, 5'b01000, 0, 0, 0, 0);
    dmb = 1; cyc("mm1", 5'b01111, 5'b10000, 0, 0, 0, 2);
    dmb = 1; mdn = 1; cyc("mm2", 5'b01111, 5'b10000, 0, 0, 0, 1);
    cyc("mm3", 5'b0, 5'b0, 0, 0, 0, 1);
    cyc("mm4", 5'b0, 5'b0, 0, 0, 0, 0);

    // jump ignored during MULDIV
    mst = 1; cyc("mj0", 5'b00111, 5'b01000, 0, 0, 0, 0);
    jmp = 1; jaddr = 64'h4444; cyc("mj1", 5'b00111, 5'b01000, 0, 0, 0, 2);
    mdn = 1; cyc("mj_done", 5'b0, 5'b0, 0, 0, 0, 2);
    cyc("mj_run", 5'b0, 5'b0, 0, 0, 0, 0);

    // asynchronous reset mid-MULDIV
    mst = 1; cyc("ar0", 5'b00111, 5'b01000, 0, 0, 0, 0);
    cyc("ar1", 5'b00111, 5'b01000, 0, 0, 0, 2);
    check("ar_pre_state", 64'(state_o), 64'd2);
    #2 rst = 1; #1;
    check("ar_state", 64'(state_o), 64'd0);
    check("ar_kill", 64'(muldiv_kill_o), 64'd0);
    check("ar_stall", 64'(stall_o), 64'd0);
    m_scnt = 0; m_rcnt = 0;
    @(posedge clk); #1;
    cyc("ar_hold", 5'b0, 5'b0, 0, 0, 0, 0);
    rst = 0;

    // counter saturation: 20 stall cycles with a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ifb = 1; cyc("sat", 5'b00001, 5'b00010, 0, 0, 0, 0);
    end
    cyc("sat_end", 5'b0, 5'b0, 0, 0, 0, 0);
    check("sat_value", 64'(stall_cnt_o), 64'd15);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
